// File: rtl/display_mux_scheduler_if.sv
// Digit-source / decoder-side signal bundle for the two-digit display multiplexer.
// master = digit source side, slave = the scheduler.
interface display_mux_scheduler_if;
  logic       en;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] dec_s;
  logic [1:0] an_n;
  logic       slot;
  logic       frame_tick;

  modport master (
    output en, digit0, digit1,
    input  dec_s, an_n, slot, frame_tick
  );

  modport slave (
    input  en, digit0, digit1,
    output dec_s, an_n, slot, frame_tick
  );
endinterface

// File: rtl/display_mux_scheduler.sv
// Shares one hex-to-7-segment decoder between two common-anode digits,
// with a blanking gap before each digit's slot to suppress ghosting.
//
// state  | meaning
// BLANK0 | both anodes off, decoder nibble tracks digit0
// SHOW0  | digit 0 anode on, nibble frozen
// BLANK1 | both anodes off, decoder nibble tracks digit1
// SHOW1  | digit 1 anode on, nibble frozen
module display_mux_scheduler #(
  parameter int SHOW_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  display_mux_scheduler_if.slave  bus
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_s_r;
  logic [1:0]       an_n_r;
  logic             slot_r;
  logic             frame_tick_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BLANK0;
      cnt          <= '0;
      dec_s_r      <= 4'h0;
      an_n_r       <= 2'b11;
      slot_r       <= 1'b0;
      frame_tick_r <= 1'b0;
    end else if (!bus.en) begin
      state        <= BLANK0;
      cnt          <= '0;
      dec_s_r      <= bus.digit0;
      an_n_r       <= 2'b11;
      slot_r       <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= 1'b0;
      cnt          <= cnt + CNT_W'(1);
      case (state)
        BLANK0: begin
          // The last blank cycle holds the nibble so the decoder settles before the anode turns on.
          if (cnt != BLANK_LAST) begin
            dec_s_r <= bus.digit0;
          end else begin
            state  <= SHOW0;
            cnt    <= '0;
            an_n_r <= 2'b10;
          end
        end
        SHOW0: begin
          if (cnt == SHOW_LAST) begin
            state  <= BLANK1;
            cnt    <= '0;
            an_n_r <= 2'b11;
            slot_r <= 1'b1;
          end
        end
        BLANK1: begin
          if (cnt != BLANK_LAST) begin
            dec_s_r <= bus.digit1;
          end else begin
            state  <= SHOW1;
            cnt    <= '0;
            an_n_r <= 2'b01;
          end
        end
        SHOW1: begin
          if (cnt == SHOW_LAST) begin
            state        <= BLANK0;
            cnt          <= '0;
            an_n_r       <= 2'b11;
            slot_r       <= 1'b0;
            frame_tick_r <= 1'b1;
          end
        end
        default: begin
          state  <= BLANK0;
          cnt    <= '0;
          an_n_r <= 2'b11;
          slot_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dec_s      = dec_s_r;
  assign bus.an_n       = an_n_r;
  assign bus.slot       = slot_r;
  assign bus.frame_tick = frame_tick_r;

  // Both PNP drivers on at once would short two digits onto one decoder.
  a_never_both_anodes: assert property (@(posedge clk) disable iff (reset) an_n_r != 2'b00);
  a_one_anode_change:  assert property (@(posedge clk) disable iff (reset)
                                        $countones(an_n_r ^ $past(an_n_r)) <= 1);

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Bench for display_mux_scheduler: constant vector table for the first frames,
// a position-based reference model feeding a scoreboard, and hand-written corner sequences.
module tb_display_mux_scheduler;

  localparam int S = 4;
  localparam int B = 2;
  localparam int P = 2 * (S + B);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  display_mux_scheduler_if bus ();

  display_mux_scheduler #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       en;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] an;
    logic       slot;
    logic       tick;
    logic [3:0] dec;
  } vec_t;

  typedef struct {
    logic [1:0] an;
    logic       slot;
    logic       tick;
    logic [3:0] dec;
  } exp_t;

  vec_t tbl [30];
  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;
  int rc       = 0;

  // reference model: position within the frame rather than an explicit state machine
  int         m_pos;
  logic [3:0] m_dec;
  logic       m_tick;
  logic [1:0] prev_an;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d t=%0t: got %0h expected %0h", name, rc, $time, act, exp);
    end
  endtask

  task automatic set_rows(int lo, int hi, logic [3:0] d0, logic [1:0] an, logic slot,
                          logic tick, logic [3:0] dec);
    for (int i = lo; i <= hi; i++) begin
      tbl[i].en   = 1'b1;
      tbl[i].d0   = d0;
      tbl[i].d1   = 4'hA;
      tbl[i].an   = an;
      tbl[i].slot = slot;
      tbl[i].tick = tick;
      tbl[i].dec  = dec;
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_dec  = 4'h0;
    m_tick = 1'b0;
  endtask

  task automatic model_step(logic en, logic [3:0] d0, logic [3:0] d1);
    if (!en) begin
      m_dec  = d0;
      m_pos  = 0;
      m_tick = 1'b0;
    end else begin
      if (m_pos < B - 1) m_dec = d0;
      else if (m_pos >= B + S && m_pos < 2 * B + S - 1) m_dec = d1;
      m_tick = (m_pos == P - 1);
      m_pos  = (m_pos + 1) % P;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    if (m_pos < B)              e.an = 2'b11;
    else if (m_pos < B + S)     e.an = 2'b10;
    else if (m_pos < 2 * B + S) e.an = 2'b11;
    else                        e.an = 2'b01;
    e.slot = (m_pos >= B + S);
    e.tick = m_tick;
    e.dec  = m_dec;
    return e;
  endfunction

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty at cycle %0d: no expectation queued", rc);
    end else begin
      e = sb.pop_front();
      chk("sb_an_n", 32'(bus.an_n), 32'(e.an));
      chk("sb_slot", 32'(bus.slot), 32'(e.slot));
      chk("sb_frame_tick", 32'(bus.frame_tick), 32'(e.tick));
      chk("sb_dec_s", 32'(bus.dec_s), 32'(e.dec));
    end
    chk("an_n_not_00", 32'(bus.an_n == 2'b00), 32'(0));
    chk("one_anode_change", 32'($countones(bus.an_n ^ prev_an) <= 1), 32'(1));
  endtask

  task automatic advance();
    model_step(bus.en, bus.digit0, bus.digit1);
    sb.push_back(model_out());
    prev_an = bus.an_n;
    @(negedge clk);
    rc++;
    sb_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_rows(0, 0, 4'h3, 2'b11, 1'b0, 1'b0, 4'h0);
    set_rows(1, 1, 4'h3, 2'b11, 1'b0, 1'b0, 4'h3);
    set_rows(2, 5, 4'h3, 2'b10, 1'b0, 1'b0, 4'h3);
    set_rows(6, 6, 4'h3, 2'b11, 1'b1, 1'b0, 4'h3);
    set_rows(7, 7, 4'h3, 2'b11, 1'b1, 1'b0, 4'hA);
    set_rows(8, 11, 4'h3, 2'b01, 1'b1, 1'b0, 4'hA);
    set_rows(12, 12, 4'h3, 2'b11, 1'b0, 1'b1, 4'hA);
    set_rows(13, 13, 4'h3, 2'b11, 1'b0, 1'b0, 4'h3);
    set_rows(14, 14, 4'h3, 2'b10, 1'b0, 1'b0, 4'h3);
    set_rows(15, 17, 4'h7, 2'b10, 1'b0, 1'b0, 4'h3);
    set_rows(18, 18, 4'h7, 2'b11, 1'b1, 1'b0, 4'h3);
    set_rows(19, 19, 4'h7, 2'b11, 1'b1, 1'b0, 4'hA);
    set_rows(20, 23, 4'h7, 2'b01, 1'b1, 1'b0, 4'hA);
    set_rows(24, 24, 4'h7, 2'b11, 1'b0, 1'b1, 4'hA);
    set_rows(25, 25, 4'h7, 2'b11, 1'b0, 1'b0, 4'h7);
    set_rows(26, 29, 4'h7, 2'b10, 1'b0, 1'b0, 4'h7);

    bus.en     = 1'b1;
    bus.digit0 = 4'h3;
    bus.digit1 = 4'hA;
    #1 reset = 1'b1;
    #2;
    chk("reset_an_n", 32'(bus.an_n), 32'(2'b11));
    chk("reset_dec_s", 32'(bus.dec_s), 32'(0));
    chk("reset_slot", 32'(bus.slot), 32'(0));
    chk("reset_frame_tick", 32'(bus.frame_tick), 32'(0));

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    prev_an = bus.an_n;
    rc = 0;
    sb.push_back(model_out());
    sb_check();

    // steady sequence and a digit0 change inside SHOW0
    for (int i = 0; i < 30; i++) begin
      chk("tbl_an_n", 32'(bus.an_n), 32'(tbl[i].an));
      chk("tbl_slot", 32'(bus.slot), 32'(tbl[i].slot));
      chk("tbl_frame_tick", 32'(bus.frame_tick), 32'(tbl[i].tick));
      chk("tbl_dec_s", 32'(bus.dec_s), 32'(tbl[i].dec));
      bus.en     = tbl[i].en;
      bus.digit0 = tbl[i].d0;
      bus.digit1 = tbl[i].d1;
      advance();
    end

    // en low for three cycles from the middle of SHOW1
    while (rc < 33) advance();
    chk("pre_disable_an_n", 32'(bus.an_n), 32'(2'b01));
    bus.en = 1'b0;
    advance();
    chk("disable_an_n", 32'(bus.an_n), 32'(2'b11));
    chk("disable_slot", 32'(bus.slot), 32'(0));
    advance();
    chk("disable_hold_an_n", 32'(bus.an_n), 32'(2'b11));
    advance();
    chk("disable_hold2_an_n", 32'(bus.an_n), 32'(2'b11));
    chk("disable_tick", 32'(bus.frame_tick), 32'(0));
    bus.en = 1'b1;
    advance();
    chk("reenable_plus1_an_n", 32'(bus.an_n), 32'(2'b11));
    chk("reenable_plus1_tick", 32'(bus.frame_tick), 32'(0));
    advance();
    chk("reenable_plus2_an_n", 32'(bus.an_n), 32'(2'b10));

    // asynchronous reset in the middle of SHOW0, between clock edges
    advance();
    chk("pre_reset_an_n", 32'(bus.an_n), 32'(2'b10));
    #1 reset = 1'b1;
    #1;
    chk("async_reset_an_n", 32'(bus.an_n), 32'(2'b11));
    chk("async_reset_dec_s", 32'(bus.dec_s), 32'(0));
    chk("async_reset_tick", 32'(bus.frame_tick), 32'(0));
    chk("async_reset_slot", 32'(bus.slot), 32'(0));
    #1 reset = 1'b0;
    sb.delete();
    model_reset();
    prev_an = bus.an_n;
    rc = 0;
    advance();
    chk("restart_c1_an_n", 32'(bus.an_n), 32'(2'b11));
    advance();
    chk("restart_c2_an_n", 32'(bus.an_n), 32'(2'b10));
    chk("restart_c2_dec_s", 32'(bus.dec_s), 32'(7));

    // digit1 changes on the last BLANK1 cycle
    while (rc < 7) advance();
    bus.digit1 = 4'h5;
    advance();
    while (rc <= 11) begin
      chk("late_d1_an_n", 32'(bus.an_n), 32'(2'b01));
      chk("late_d1_dec_s_held", 32'(bus.dec_s), 32'(4'hA));
      advance();
    end
    while (rc < 20) advance();
    chk("late_d1_next_frame_an_n", 32'(bus.an_n), 32'(2'b01));
    chk("late_d1_next_frame_dec_s", 32'(bus.dec_s), 32'(4'h5));

    // free run with changing digits: frame and slot cadence
    while (rc < 120) begin
      chk("free_frame_tick", 32'(bus.frame_tick), 32'((rc % P == 0) && (rc > 0)));
      chk("free_slot", 32'(bus.slot), 32'((rc % P) >= (B + S)));
      bus.digit0 = 4'($urandom_range(0, 15));
      bus.digit1 = 4'($urandom_range(0, 15));
      advance();
    end

    // random enable dropouts, checked against the model only
    for (int i = 0; i < 300; i++) begin
      bus.en     = ($urandom_range(0, 9) != 0);
      bus.digit0 = 4'($urandom_range(0, 15));
      bus.digit1 = 4'($urandom_range(0, 15));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
